reg_file_param: RTL and testbench
=================================

Name: reg_file_param

Overview:
- Parametrised successor to the CPU's 8x16 register file: configurable width and depth, optional hardwired zero register, two independent read ports plus one fixed tap port, and optional write-to-read bypass.
- Adds a Start-triggered clear sweep that zeroes the array one entry per cycle, with Busy and dropped-write reporting.
- Sits between decode (source/dest addresses) and the ALU/memory datapath.

Parameters:
- WIDTH, 16, data width in bits.
- DEPTH, 8, number of registers; power of two, at least 2.
- AW, clog2(DEPTH), address width (derived; not overridden).
- ZERO_REG, 1, if 1 then register 0 always reads 0 and ignores writes.
- BYPASS, 1, if 1 then same-cycle write data is forwarded to matching read ports.
- TAP_REG, 6, index of the register continuously driven on ReadTap; must be less than DEPTH.

Ports:
- CLK, input, 1, clock; all state updates on the rising edge only.
- Reset, input, 1, asynchronous, active-high reset.
- Start, input, 1, request a clear sweep of the whole array.
- RegWrite, input, 1, write enable.
- WriteReg, input, AW, destination index.
- WriteValue, input, WIDTH, write data.
- SrcA, input, AW, read port A index.
- SrcB, input, AW, read port B index.
- ReadA, output, WIDTH, combinational read data for SrcA.
- ReadB, output, WIDTH, combinational read data for SrcB.
- ReadTap, output, WIDTH, contents of register TAP_REG.
- Busy, output, 1, high while a clear sweep is in progress.
- WriteDropped, output, 1, registered one-cycle pulse reporting a write that was rejected.

Behaviour:
- Reset (asynchronous, active-high; one clock; no other clock domains):
  - All DEPTH registers go to 0.
  - FSM goes to IDLE and the sweep index to 0.
  - Busy=0 and WriteDropped=0 immediately, without waiting for a clock edge.
  - Reset asserted mid-sweep aborts the sweep; the FSM is in IDLE after release.
- FSM states:
  - IDLE: on a rising edge with Start=1, go to CLEAR with idx=0.
  - CLEAR: on each rising edge, registers[idx] is set to 0 and idx increments. At idx==DEPTH-1, that entry is cleared and the FSM returns to IDLE.
  - A sweep therefore lasts exactly DEPTH cycles.
  - Busy = (state==CLEAR), decoded from state with no extra latency.
  - Start while Busy is ignored; a sweep does not restart.
- Writes:
  - In IDLE, RegWrite=1 writes WriteValue into registers[WriteReg] at the rising edge.
  - A write to register 0 is discarded when ZERO_REG=1. This is not a dropped write; WriteDropped stays 0.
  - A write in the same cycle as Start in IDLE is performed; the sweep starts next cycle.
  - RegWrite=1 while Busy is discarded, and WriteDropped=1 for exactly the following cycle.
- Reads (combinational, zero latency):
  - ReadX = 0 if ZERO_REG and SrcX==0.
  - Otherwise, if BYPASS and RegWrite and !Busy and WriteReg==SrcX and the write is not discarded, ReadX = WriteValue.
  - Otherwise ReadX = registers[SrcX].
  - ReadTap = registers[TAP_REG]. It is never bypassed; it is 0 when TAP_REG==0 and ZERO_REG=1.
  - During CLEAR, reads return the partially cleared array contents.
  - Both read ports may address the same register.
- Width rules:
  - Out-of-range indices are impossible by construction (DEPTH = 2^AW).
  - No sign extension or truncation anywhere.

Test Plan:
- Reset, then write 16'h1234 to reg 5 and 16'hBEEF to reg 6. Required: ReadA(SrcA=5)=1234 after the edge, ReadTap=BEEF.
- ZERO_REG=1: write 16'hFFFF to reg 0. Required: ReadA(SrcA=0)=0, WriteDropped stays 0.
- BYPASS=1: RegWrite with WriteReg=3, WriteValue=16'h00A5, SrcA=SrcB=3. Required: ReadA=ReadB=00A5 in the same cycle, before the edge. With BYPASS=0, both show the old value until the edge.
- Fill all regs with nonzero data, pulse Start. Required: Busy high for exactly 8 cycles; reg k reads 0 after sweep cycle k; a write attempted at cycle 3 is lost and WriteDropped pulses once, on cycle 4.
- Start a sweep, assert Reset at cycle 4. Required: Busy drops and all regs read 0 immediately (async); after release the FSM is in IDLE and a normal write succeeds.
- WIDTH=32, DEPTH=32, TAP_REG=31: write 32'hDEADBEEF to reg 31. Required: ReadTap=DEADBEEF; a subsequent sweep takes 32 cycles.

Source files
------------

// File: rtl/reg_file_param.sv
// Parametrised register file: two bypassable read ports, a fixed tap, and a
// Start-triggered clear sweep that zeroes one entry per cycle.
module reg_file_param #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 8,
   parameter int AW       = $clog2(DEPTH),
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1,
   parameter int TAP_REG  = 6
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Start,
   input  logic             RegWrite,
   input  logic [AW-1:0]    WriteReg,
   input  logic [WIDTH-1:0] WriteValue,
   input  logic [AW-1:0]    SrcA,
   input  logic [AW-1:0]    SrcB,
   output logic [WIDTH-1:0] ReadA,
   output logic [WIDTH-1:0] ReadB,
   output logic [WIDTH-1:0] ReadTap,
   output logic             Busy,
   output logic             WriteDropped
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [AW-1:0] TAP_IDX  = AW'(TAP_REG);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   state_t           state;
   logic [AW-1:0]    idx;
   logic [WIDTH-1:0] regs [DEPTH];
   logic             wr_ok;
   logic             byp_a, byp_b;

   assign Busy = (state == CLEAR);

   // A write lands only when idle and not aimed at the hardwired zero entry.
   assign wr_ok = RegWrite && !Busy && !(ZERO_REG && (WriteReg == '0));

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state        <= IDLE;
         idx          <= '0;
         WriteDropped <= 1'b0;
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         WriteDropped <= RegWrite && Busy;
         case (state)
            IDLE: begin
               if (wr_ok) regs[WriteReg] <= WriteValue;
               if (Start) begin
                  state <= CLEAR;
                  idx   <= '0;
               end
            end
            CLEAR: begin
               regs[idx] <= '0;
               idx       <= idx + 1'b1;
               if (idx == LAST_IDX) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign byp_a = BYPASS && wr_ok && (WriteReg == SrcA);
   assign byp_b = BYPASS && wr_ok && (WriteReg == SrcB);

   assign ReadA   = (ZERO_REG && (SrcA == '0)) ? '0 : byp_a ? WriteValue : regs[SrcA];
   assign ReadB   = (ZERO_REG && (SrcB == '0)) ? '0 : byp_b ? WriteValue : regs[SrcB];
   assign ReadTap = (ZERO_REG && (TAP_REG == 0)) ? '0 : regs[TAP_IDX];

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: default, no-bypass and 32x32 instances.
module tb_reg_file_param;

   logic        CLK = 1'b0, Reset = 1'b1, Start = 1'b0, RegWrite = 1'b0;
   logic [2:0]  WriteReg = '0, SrcA = '0, SrcB = '0;
   logic [15:0] WriteValue = '0;
   logic [15:0] ra, rb, rt, na, nb, nt;
   logic        busy, wd, nbusy, nwd;

   logic        wStart = 1'b0, wRegWrite = 1'b0;
   logic [4:0]  wWriteReg = '0, wSrcA = '0, wSrcB = '0;
   logic [31:0] wWriteValue = '0, wa, wb, wt;
   logic        wbusy, wwd;

   int checks = 0, errors = 0;

   always #5 CLK = ~CLK;

   reg_file_param u_dut (
      .CLK(CLK), .Reset(Reset), .Start(Start), .RegWrite(RegWrite),
      .WriteReg(WriteReg), .WriteValue(WriteValue), .SrcA(SrcA), .SrcB(SrcB),
      .ReadA(ra), .ReadB(rb), .ReadTap(rt), .Busy(busy), .WriteDropped(wd));

   reg_file_param #(.BYPASS(1'b0)) u_nb (
      .CLK(CLK), .Reset(Reset), .Start(Start), .RegWrite(RegWrite),
      .WriteReg(WriteReg), .WriteValue(WriteValue), .SrcA(SrcA), .SrcB(SrcB),
      .ReadA(na), .ReadB(nb), .ReadTap(nt), .Busy(nbusy), .WriteDropped(nwd));

   reg_file_param #(.WIDTH(32), .DEPTH(32), .TAP_REG(31)) u_wide (
      .CLK(CLK), .Reset(Reset), .Start(wStart), .RegWrite(wRegWrite),
      .WriteReg(wWriteReg), .WriteValue(wWriteValue), .SrcA(wSrcA), .SrcB(wSrcB),
      .ReadA(wa), .ReadB(wb), .ReadTap(wt), .Busy(wbusy), .WriteDropped(wwd));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rw;
      logic [2:0]  wreg;
      logic [15:0] wval;
      logic [2:0]  sa, sb;
      logic [15:0] ea, eb, ena, enb, et;
   } vec_t;

   vec_t vt [6];
   int   cnt;

   initial begin
      // rw wreg wval     sa    sb    ea        eb        ena       enb       et
      vt[0] = '{1'b1, 3'd5, 16'h1234, 3'd5, 3'd6, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      vt[1] = '{1'b1, 3'd6, 16'hBEEF, 3'd5, 3'd6, 16'h1234, 16'hBEEF, 16'h1234, 16'h0000, 16'hBEEF};
      vt[2] = '{1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd5, 16'h0000, 16'h1234, 16'h0000, 16'h1234, 16'hBEEF};
      vt[3] = '{1'b1, 3'd3, 16'h00A5, 3'd3, 3'd3, 16'h00A5, 16'h00A5, 16'h0000, 16'h0000, 16'hBEEF};
      vt[4] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd0, 16'h00A5, 16'h0000, 16'h00A5, 16'h0000, 16'hBEEF};
      vt[5] = '{1'b1, 3'd6, 16'h5A5A, 3'd6, 3'd6, 16'h5A5A, 16'h5A5A, 16'hBEEF, 16'hBEEF, 16'h5A5A};

      // reset state, held across clock edges
      SrcA = 3'd5;
      repeat (2) @(negedge CLK);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_wd", wd, 1'b0);
      chk("rst_tap", rt, 16'h0);
      chk("rst_reada", ra, 16'h0);
      @(negedge CLK) Reset = 1'b0;

      // table: comb reads before the edge, registered state after it
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         RegWrite = vt[i].rw; WriteReg = vt[i].wreg; WriteValue = vt[i].wval;
         SrcA = vt[i].sa; SrcB = vt[i].sb;
         #1;
         chk($sformatf("v%0d_a", i), ra, vt[i].ea);
         chk($sformatf("v%0d_b", i), rb, vt[i].eb);
         chk($sformatf("v%0d_nb_a", i), na, vt[i].ena);
         chk($sformatf("v%0d_nb_b", i), nb, vt[i].enb);
         @(posedge CLK); #1;
         chk($sformatf("v%0d_tap", i), rt, vt[i].et);
         chk($sformatf("v%0d_nb_tap", i), nt, vt[i].et);
         chk($sformatf("v%0d_busy", i), busy, 1'b0);
         chk($sformatf("v%0d_wd", i), wd, 1'b0);
      end

      // fill regs 1..7 with k*1111, then sweep
      for (int k = 1; k < 8; k++) begin
         @(negedge CLK);
         RegWrite = 1'b1; WriteReg = 3'(k); WriteValue = 16'(k * 16'h1111);
      end
      @(negedge CLK) RegWrite = 1'b0;
      #1;
      chk("fill_tap", rt, 16'h6666);
      chk("fill_busy", busy, 1'b0);
      Start = 1'b1;
      @(posedge CLK); #1;
      chk("sweep_busy_start", busy, 1'b1);
      for (int c = 1; c <= 8; c++) begin
         @(negedge CLK);
         SrcA = 3'(c - 1); SrcB = 3'(c);
         RegWrite = (c == 3); WriteReg = 3'd1; WriteValue = 16'hFFFF;
         Start = (c == 5);
         @(posedge CLK); #1;
         chk($sformatf("sweep%0d_busy", c), busy, (c < 8));
         chk($sformatf("sweep%0d_cleared", c), ra, 16'h0);
         if (c < 8) chk($sformatf("sweep%0d_next", c), rb, 32'(c * 32'h1111));
         chk($sformatf("sweep%0d_wd", c), wd, (c == 3));
      end
      @(negedge CLK);
      RegWrite = 1'b0; Start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         SrcA = 3'(k);
         #1 chk($sformatf("swept_r%0d", k), ra, 16'h0);
      end
      @(posedge CLK); #1;
      chk("sweep_no_restart", busy, 1'b0);

      // reset in the middle of a sweep
      @(negedge CLK);
      RegWrite = 1'b1; WriteReg = 3'd6; WriteValue = 16'h6666;
      @(negedge CLK);
      RegWrite = 1'b0; Start = 1'b1; SrcA = 3'd6;
      @(posedge CLK);
      @(negedge CLK) Start = 1'b0;
      repeat (3) @(posedge CLK);
      #1 chk("midsweep_busy", busy, 1'b1);
      chk("midsweep_r6", ra, 16'h6666);
      #1 Reset = 1'b1;
      #1;
      chk("async_busy", busy, 1'b0);
      chk("async_tap", rt, 16'h0);
      chk("async_r6", ra, 16'h0);
      chk("async_wd", wd, 1'b0);
      @(negedge CLK) Reset = 1'b0;
      #1 chk("post_rst_busy", busy, 1'b0);
      RegWrite = 1'b1; WriteReg = 3'd4; WriteValue = 16'h4444; SrcA = 3'd4;
      @(posedge CLK);
      @(negedge CLK) RegWrite = 1'b0;
      #1;
      chk("post_rst_write", ra, 16'h4444);
      chk("post_rst_idle", busy, 1'b0);

      // 32x32 instance
      wRegWrite = 1'b1; wWriteReg = 5'd31; wWriteValue = 32'hDEADBEEF;
      @(posedge CLK); #1;
      chk("wide_tap", wt, 32'hDEADBEEF);
      @(negedge CLK);
      wWriteReg = 5'd0; wWriteValue = 32'hFFFFFFFF; wSrcA = 5'd0;
      #1 chk("wide_r0_pre", wa, 32'h0);
      @(posedge CLK); #1;
      chk("wide_r0_post", wa, 32'h0);
      chk("wide_r0_wd", wwd, 1'b0);
      @(negedge CLK);
      wRegWrite = 1'b0; wStart = 1'b1;
      @(posedge CLK); #1;
      @(negedge CLK) wStart = 1'b0;
      cnt = 0;
      while (wbusy && cnt < 100) begin
         cnt++;
         @(posedge CLK); #1;
      end
      chk("wide_sweep_cycles", cnt, 32'd32);
      chk("wide_sweep_tap", wt, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
